// File: rtl/cap_err_rsp_chk_if.sv
// Bundle between the capability error injector, the core trap stream and the
// response checker; master drives the records and traps, slave is the checker.
interface cap_err_rsp_chk_if #(
  parameter int CNT_W = 16
);
  logic             chk_enable;
  logic             inj_valid;
  logic [7:0]       inj_flag;
  logic             inj_is_cap;
  logic             inj_we;
  logic [31:0]      inj_pc;
  logic             exc_valid;
  logic             exc_cheri;
  logic [4:0]       exc_cause;
  logic [31:0]      exc_pc;
  logic             pending;
  logic             chk_pass;
  logic             chk_fail;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] inj_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] skip_cnt;
  logic             overflow;

  modport master (
    output chk_enable, inj_valid, inj_flag, inj_is_cap, inj_we, inj_pc,
    output exc_valid, exc_cheri, exc_cause, exc_pc,
    input  pending, chk_pass, chk_fail, fail_code,
    input  inj_cnt, pass_cnt, fail_cnt, skip_cnt, overflow
  );

  modport slave (
    input  chk_enable, inj_valid, inj_flag, inj_is_cap, inj_we, inj_pc,
    input  exc_valid, exc_cheri, exc_cause, exc_pc,
    output pending, chk_pass, chk_fail, fail_code,
    output inj_cnt, pass_cnt, fail_cnt, skip_cnt, overflow
  );
endinterface

// File: rtl/cap_err_rsp_chk.sv
// Matches each injected CHERI load/store error against the trap the core takes,
// resolving every queued expectation as pass, cause mismatch or timeout.
module cap_err_rsp_chk #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  cap_err_rsp_chk_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_WAIT = 1'b1} state_t;

  // bad marks an unmappable record: it always resolves as a cause mismatch
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  prim;
    logic [5:0]  alt;
    logic        bad;
  } exp_t;

  function automatic exp_t map_exp(input logic [7:0]  flag,
                                   input logic        is_cap,
                                   input logic        we,
                                   input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.bad  = 1'b0;
    e.prim = {1'b1, 5'h01};
    case (flag[2:0])
      3'd0: e.prim = {1'b1, 5'h02};
      3'd1: e.prim = {1'b1, 5'h03};
      3'd2: e.prim = we ? {1'b1, 5'h13} : {1'b1, 5'h12};
      3'd3: e.prim = {1'b1, 5'h01};
      3'd4: begin
        if (is_cap) begin
          e.prim = we ? {1'b0, 5'h06} : {1'b0, 5'h04};
        end else begin
          e.prim = {1'b1, 5'h01};
          e.bad  = 1'b1;
        end
      end
      default: begin
        e.prim = {1'b1, 5'h01};
        e.bad  = 1'b1;
      end
    endcase
    e.alt = ((flag[2:0] == 3'd2) && is_cap && we) ? {1'b1, 5'h15} : e.prim;
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  exp_t             mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r, count_nxt_s;
  state_t           state_r;
  logic [TW-1:0]    timer_r;
  logic             pending_r, pass_r, fail_r, overflow_r;
  logic [1:0]       fail_code_r;
  logic [CNT_W-1:0] inj_cnt_r, pass_cnt_r, fail_cnt_r, skip_cnt_r;

  exp_t       head_s, push_ent_s;
  logic [5:0] exc_code_s;
  logic       full_s, push_req_s, push_ok_s, ovf_s, skip_s;
  logic       pc_hit_s, tmo_s, pop_s, res_pass_s, res_fail_s;
  logic       unused_flag_s;

  assign unused_flag_s = ^bus.inj_flag[6:3];

  // Head match / timeout decision and FIFO occupancy bookkeeping
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    push_ent_s = map_exp(bus.inj_flag, bus.inj_is_cap, bus.inj_we, bus.inj_pc);
    exc_code_s = {bus.exc_cheri, bus.exc_cause};
    full_s     = (count_r == (AW+1)'(DEPTH));
    push_req_s = bus.inj_valid & bus.chk_enable & ~bus.inj_flag[7];
    skip_s     = bus.inj_valid & bus.inj_flag[7];
    pc_hit_s   = (state_r == ST_WAIT) && bus.exc_valid && (bus.exc_pc == head_s.pc);
    tmo_s      = (state_r == ST_WAIT) && !pc_hit_s && (timer_r == TW'(TIMEOUT));
    pop_s      = pc_hit_s | tmo_s;
    res_pass_s = pc_hit_s && !head_s.bad &&
                 ((exc_code_s == head_s.prim) || (exc_code_s == head_s.alt));
    res_fail_s = pop_s && !res_pass_s;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    push_ok_s  = push_req_s && (!full_s || pop_s);
    ovf_s      = push_req_s && full_s && !pop_s;
    if (push_ok_s && !pop_s) begin
      count_nxt_s = count_r + (AW+1)'(1);
    end else if (!push_ok_s && pop_s) begin
      count_nxt_s = count_r - (AW+1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Expectation storage; contents are only read while an entry is valid
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_ent_s;
    end
  end

  // FIFO pointers, occupancy and the registered pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      pending_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r   <= count_nxt_s;
      pending_r <= (count_nxt_s != '0);
    end
  end

  // Head state machine with its timer and the resolution pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      timer_r     <= '0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_code_r <= 2'b00;
    end else begin
      pass_r      <= res_pass_s;
      fail_r      <= res_fail_s;
      fail_code_r <= !res_fail_s ? 2'b00 :
                     (tmo_s && !head_s.bad) ? 2'b10 : 2'b01;
      case (state_r)
        ST_EMPTY: begin
          timer_r <= '0;
          if (push_ok_s) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pop_s) begin
            timer_r <= '0;
            if (count_nxt_s == '0) begin
              state_r <= ST_EMPTY;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          timer_r <= '0;
        end
      endcase
    end
  end

  // Saturating statistics and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt_r  <= '0;
      pass_cnt_r <= '0;
      fail_cnt_r <= '0;
      skip_cnt_r <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        inj_cnt_r <= sat_inc(inj_cnt_r);
      end
      if (res_pass_s) begin
        pass_cnt_r <= sat_inc(pass_cnt_r);
      end
      if (res_fail_s) begin
        fail_cnt_r <= sat_inc(fail_cnt_r);
      end
      if (skip_s) begin
        skip_cnt_r <= sat_inc(skip_cnt_r);
      end
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.pending   = pending_r;
  assign bus.chk_pass  = pass_r;
  assign bus.chk_fail  = fail_r;
  assign bus.fail_code = fail_code_r;
  assign bus.inj_cnt   = inj_cnt_r;
  assign bus.pass_cnt  = pass_cnt_r;
  assign bus.fail_cnt  = fail_cnt_r;
  assign bus.skip_cnt  = skip_cnt_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_cap_err_rsp_chk.sv
// Directed and randomized bench for cap_err_rsp_chk against a queue-based
// reference model of the expectation/trap matching rules.
module tb_cap_err_rsp_chk;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cap_err_rsp_chk_if #(.CNT_W(CNT_W)) bus ();

  cap_err_rsp_chk #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  p;
    logic [5:0]  a;
    bit          bad;
  } ent_t;

  ent_t q[$];
  int   head_age;
  int   e_pass, e_fail, e_code, e_inj, e_pcnt, e_fcnt, e_skip, e_ovf;
  int   errors = 0;
  int   checks = 0;

  function automatic int sat(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  // Expected trap codes straight from the injection-type table
  function automatic ent_t mk_ent(input logic [7:0] f, input logic c, input logic w,
                                  input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.bad = 1'b0;
    case (f[2:0])
      3'd0: e.p = 6'h22;
      3'd1: e.p = 6'h23;
      3'd2: e.p = w ? 6'h33 : 6'h32;
      3'd3: e.p = 6'h21;
      3'd4: begin
        if (c) e.p = w ? 6'h06 : 6'h04;
        else begin e.p = 6'h21; e.bad = 1'b1; end
      end
      default: begin e.p = 6'h21; e.bad = 1'b1; end
    endcase
    e.a = (f[2:0] == 3'd2 && c && w) ? 6'h35 : e.p;
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    head_age = 0;
    e_pass = 0; e_fail = 0; e_code = 0;
    e_inj = 0; e_pcnt = 0; e_fcnt = 0; e_skip = 0; e_ovf = 0;
  endtask

  task automatic model_step();
    bit popped;
    popped = 1'b0;
    e_pass = 0; e_fail = 0; e_code = 0;
    if (q.size() > 0) begin
      if (bus.exc_valid && bus.exc_pc == q[0].pc) begin
        popped = 1'b1;
        if (!q[0].bad && ({bus.exc_cheri, bus.exc_cause} == q[0].p ||
                          {bus.exc_cheri, bus.exc_cause} == q[0].a)) e_pass = 1;
        else begin e_fail = 1; e_code = 1; end
      end else if (head_age == TIMEOUT) begin
        popped = 1'b1;
        e_fail = 1;
        e_code = q[0].bad ? 1 : 2;
      end
      if (popped) begin
        q.delete(0);
        head_age = 0;
        if (e_pass != 0) e_pcnt = sat(e_pcnt);
        else e_fcnt = sat(e_fcnt);
      end else begin
        head_age++;
      end
    end
    if (bus.inj_valid && bus.inj_flag[7]) e_skip = sat(e_skip);
    if (bus.inj_valid && bus.chk_enable && !bus.inj_flag[7]) begin
      if (q.size() < DEPTH) begin
        q.push_back(mk_ent(bus.inj_flag, bus.inj_is_cap, bus.inj_we, bus.inj_pc));
        e_inj = sat(e_inj);
      end else begin
        e_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("chk_pass", 64'(bus.chk_pass), 64'(e_pass));
    chk("chk_fail", 64'(bus.chk_fail), 64'(e_fail));
    if (e_fail != 0) chk("fail_code", 64'(bus.fail_code), 64'(e_code));
    chk("pending", 64'(bus.pending), 64'(q.size() != 0));
    chk("inj_cnt", 64'(bus.inj_cnt), 64'(e_inj));
    chk("pass_cnt", 64'(bus.pass_cnt), 64'(e_pcnt));
    chk("fail_cnt", 64'(bus.fail_cnt), 64'(e_fcnt));
    chk("skip_cnt", 64'(bus.skip_cnt), 64'(e_skip));
    chk("overflow", 64'(bus.overflow), 64'(e_ovf));
  endtask

  // One clock: model consumes this cycle's inputs, DUT checked on the falling edge
  task automatic tick();
    if (rst_n) model_step();
    else model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    bus.inj_valid = 1'b0;
    bus.exc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic inj(input logic [7:0] f, input logic c, input logic w, input logic [31:0] pc);
    bus.inj_valid = 1'b1; bus.inj_flag = f; bus.inj_is_cap = c; bus.inj_we = w; bus.inj_pc = pc;
  endtask

  task automatic trap(input logic ch, input logic [4:0] cause, input logic [31:0] pc);
    bus.exc_valid = 1'b1; bus.exc_cheri = ch; bus.exc_cause = cause; bus.exc_pc = pc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  code;
    logic [7:0]  f;
    logic [31:0] pc;
    bus.chk_enable = 1'b1;
    bus.inj_valid = 1'b0; bus.inj_flag = 8'h00; bus.inj_is_cap = 1'b0;
    bus.inj_we = 1'b0; bus.inj_pc = 32'h0;
    bus.exc_valid = 1'b0; bus.exc_cheri = 1'b0; bus.exc_cause = 5'h0; bus.exc_pc = 32'h0;
    model_reset();
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;

    // CLC tag error, trap five cycles later
    inj(8'h00, 1'b1, 1'b0, 32'h8000_1000); tick();
    idle(4);
    trap(1'b1, 5'h02, 32'h8000_1000); tick(); tick();

    // CSC address error: alternate cause passes, unrelated cause fails
    inj(8'h02, 1'b1, 1'b1, 32'h8000_1100); tick(); idle(2);
    trap(1'b1, 5'h15, 32'h8000_1100); tick(); tick();
    inj(8'h02, 1'b1, 1'b1, 32'h8000_1200); tick(); idle(1);
    trap(1'b1, 5'h12, 32'h8000_1200); tick(); tick();

    // RV32 load with no trap -> timeout
    inj(8'h43, 1'b0, 1'b0, 32'h8000_1300); tick();
    idle(TIMEOUT + 3);

    // Overflow, then push + pop while full
    for (int i = 0; i < 5; i++) begin
      inj(8'h03, 1'b0, 1'b1, 32'h8000_1400 + 32'(i * 4)); tick();
    end
    idle(2);
    inj(8'h01, 1'b1, 1'b0, 32'h8000_1500);
    trap(1'b1, 5'h01, 32'h8000_1400); tick();
    for (int i = 1; i < 4; i++) begin
      trap(1'b1, 5'h01, 32'h8000_1400 + 32'(i * 4)); tick();
    end
    trap(1'b1, 5'h03, 32'h8000_1500); tick(); tick();

    // Abandoned injection and disabled checker
    inj(8'h83, 1'b1, 1'b0, 32'h8000_1600); tick(); tick();
    bus.chk_enable = 1'b0;
    inj(8'h00, 1'b1, 1'b0, 32'h8000_1700); tick(); tick();
    bus.chk_enable = 1'b1;

    // Interrupt in WAIT is ignored, then the real trap
    inj(8'h01, 1'b0, 1'b0, 32'h8000_1800); tick(); tick();
    trap(1'b0, 5'h0b, 32'h0000_0100); tick();
    trap(1'b1, 5'h03, 32'h8000_1800); tick(); tick();

    // Type 4 CSC store, unmappable type, and a trap in the push cycle
    inj(8'h04, 1'b1, 1'b1, 32'h8000_1900); tick();
    trap(1'b0, 5'h06, 32'h8000_1900); tick(); tick();
    inj(8'h05, 1'b0, 1'b0, 32'h8000_1a00); tick();
    trap(1'b1, 5'h01, 32'h8000_1a00); tick(); tick();
    inj(8'h00, 1'b1, 1'b0, 32'h8000_1b00);
    trap(1'b1, 5'h02, 32'h8000_1b00); tick();
    trap(1'b1, 5'h02, 32'h8000_1b00); tick(); tick();

    // Randomized traffic: busy trap phase, then sparse traps for timeouts
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(3, 0) == 0) begin
          f = 8'($urandom) & 8'h47;
          if ($urandom_range(7, 0) == 0) f[7] = 1'b1;
          pc = 32'h8000_2000 + 32'($urandom_range(7, 0) * 4);
          bus.chk_enable = ($urandom_range(9, 0) != 0);
          inj(f, 1'($urandom), 1'($urandom), pc);
        end
        if (q.size() > 0 && $urandom_range(ph == 0 ? 2 : 60, 0) == 0) begin
          case ($urandom_range(2, 0))
            0: code = q[0].p;
            1: code = q[0].a;
            default: code = 6'($urandom);
          endcase
          trap(code[5], code[4:0], q[0].pc);
        end else if ($urandom_range(9, 0) == 0) begin
          trap(1'($urandom), 5'($urandom), 32'h0000_0200 + 32'($urandom_range(3, 0) * 4));
        end
        tick();
      end
    end
    bus.chk_enable = 1'b1;
    idle(TIMEOUT * DEPTH + 8);

    // Reset with two expectations pending
    inj(8'h00, 1'b1, 1'b0, 32'h8000_3000); tick();
    inj(8'h01, 1'b1, 1'b0, 32'h8000_3004); tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    trap(1'b1, 5'h02, 32'h8000_3000); tick();
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
